lsm_sequencer: RTL and testbench
================================

Name: lsm_sequencer

Overview:
- Sequences ARM load/store-multiple (LDM/STM) transfers for the microprogrammed control unit.
- Latches the 16-bit register list from IR[15:0] and the P/U addressing bits, then walks the set bits in ascending register order. For each transfer it presents a register number and a word address.
- Raises LSM_DETECT and LSM_END so the control unit's next-state logic can loop its transfer microstate, and produces the base write-back address.
- Sits between the instruction register / register-file base read and the control unit's LSM_DETECT/LSM_END condition inputs.

Parameters:
ADDR_W, 32, width of base, transfer and write-back addresses
STEP, 4, byte increment per transferred word

Ports:
CLK  input  1  system clock, rising edge
nRESET  input  1  asynchronous active-low reset
LOAD  input  1  control word LSM_EN: capture list/base/P/U (honoured only in IDLE)
NEXT  input  1  current transfer finished (asserted by control unit after MOC); advance
IR_LIST  input  16  register list, IR[15:0]
P_BIT  input  1  IR[24]: 1 = pre-index (before), 0 = post-index (after)
U_BIT  input  1  IR[23]: 1 = increment, 0 = decrement
BASE  input  ADDR_W  base register value Rn
REG_NUM  output  4  register index of current transfer
ADDR  output  ADDR_W  memory address of current transfer
LSM_DETECT  output  1  sequence active (state ACTIVE)
LSM_END  output  1  current transfer is the last one
WB_ADDR  output  ADDR_W  base write-back value, valid from the first ACTIVE cycle until next LOAD
COUNT  output  5  number of transfers remaining, including the current one
BUSY  output  1  state != IDLE

Behaviour:
- Reset (async, nRESET=0): state IDLE; list register 0; REG_NUM 0; ADDR 0; WB_ADDR 0; COUNT 0; LSM_DETECT 0; LSM_END 0; BUSY 0.
- States are IDLE, ACTIVE and DONE.
- IDLE + LOAD=1:
  - n = popcount(IR_LIST) (0..16).
  - If n=0: stay IDLE; WB_ADDR<=BASE; no transfer; LSM_DETECT stays 0.
  - Else latch the list and go to ACTIVE next edge. Start address and write-back by mode:
    - IA (P=0,U=1): start = BASE; WB_ADDR = BASE+STEP*n.
    - IB (P=1,U=1): start = BASE+STEP; WB_ADDR = BASE+STEP*n.
    - DA (P=0,U=0): start = BASE-STEP*n+STEP; WB_ADDR = BASE-STEP*n.
    - DB (P=1,U=0): start = BASE-STEP*n; WB_ADDR = BASE-STEP*n.
  - Address arithmetic is modulo 2^ADDR_W (wrap, no flag).
- ACTIVE:
  - REG_NUM = index of lowest set bit of the latched list (priority encoder on registered list).
  - ADDR = registered current address.
  - COUNT = popcount of remaining list.
  - LSM_DETECT=1; LSM_END = (COUNT==1), combinational from registered state.
- ACTIVE + NEXT=1:
  - Clear the lowest set bit; ADDR<=ADDR+STEP (always ascending); REG_NUM and COUNT update next cycle.
  - If LSM_END was 1: go to DONE, list becomes 0.
- ACTIVE + NEXT=0: hold all outputs; no timeout.
- DONE: LSM_DETECT=0, LSM_END=0, COUNT=0, BUSY=1 for exactly one cycle, then IDLE. WB_ADDR is held.
- Ignored inputs:
  - LOAD outside IDLE.
  - NEXT in IDLE or DONE.
  - LOAD and NEXT together in IDLE: LOAD is taken.
- Latency: LOAD edge to first valid REG_NUM/ADDR is 1 cycle; NEXT edge to the following transfer is 1 cycle; last NEXT to BUSY=0 is 2 cycles.
- IR_LIST/BASE/P/U are sampled only at the LOAD edge; later changes have no effect.
- Reset mid-sequence: immediate return to the reset values above; no partial write-back is retained.

Test Plan:
- Apply reset mid-sim -> all outputs 0, state IDLE immediately, without waiting for a CLK edge.
- IA: IR_LIST=0x8005, BASE=0x100, P=0,U=1, LOAD, then NEXT each cycle -> (REG_NUM,ADDR) = (0,0x100),(2,0x104),(15,0x108). LSM_END only on the third; COUNT 3,2,1; WB_ADDR=0x10C; BUSY drops 2 cycles after last NEXT.
- Same list, other modes: IB start 0x104, WB 0x10C; DA start 0xF8, WB 0xF4; DB start 0xF4, WB 0xF4. Register order is 0,2,15 in all modes.
- IR_LIST=0x0000 with LOAD -> stays IDLE, LSM_DETECT never 1, WB_ADDR=BASE.
- IR_LIST=0xFFFF, BASE=0xFFFFFFF8, IA -> 16 transfers, ADDR wraps 0xFFFFFFFC -> 0x00000000, COUNT starts at 16, WB_ADDR=0x38.
- NEXT held low 5 cycles in ACTIVE -> outputs frozen. LOAD asserted while ACTIVE with a new list -> ignored, sequence unchanged.

Source files
------------

// File: rtl/lsm_sequencer_if.sv
// Handshake/bus bundle between the control unit and the LDM/STM sequencer.
// The control unit is the master and drives LOAD, NEXT and the captured instruction fields.
interface lsm_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              LOAD;
  logic              NEXT;
  logic [15:0]       IR_LIST;
  logic              P_BIT;
  logic              U_BIT;
  logic [ADDR_W-1:0] BASE;
  logic [3:0]        REG_NUM;
  logic [ADDR_W-1:0] ADDR;
  logic              LSM_DETECT;
  logic              LSM_END;
  logic [ADDR_W-1:0] WB_ADDR;
  logic [4:0]        COUNT;
  logic              BUSY;

  modport master (
    output LOAD, NEXT, IR_LIST, P_BIT, U_BIT, BASE,
    input  REG_NUM, ADDR, LSM_DETECT, LSM_END, WB_ADDR, COUNT, BUSY
  );

  modport slave (
    input  LOAD, NEXT, IR_LIST, P_BIT, U_BIT, BASE,
    output REG_NUM, ADDR, LSM_DETECT, LSM_END, WB_ADDR, COUNT, BUSY
  );
endinterface

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: walks the latched register list in ascending order,
// presenting one register number and word address per transfer, plus the base write-back value.
module lsm_sequencer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP   = 4
) (
  input  logic              CLK,
  input  logic              nRESET,
  lsm_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wb_q, wb_d;

  logic [4:0]        load_cnt;
  logic [4:0]        list_cnt;
  logic [3:0]        low_idx;
  logic [ADDR_W-1:0] step_n;
  logic              last_xfer;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  always_comb begin
    load_cnt = popcount16(bus.IR_LIST);
    list_cnt = popcount16(list_q);
    step_n   = ADDR_W'(STEP * 32'(load_cnt));
  end

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) begin
        low_idx = 4'(i);
      end
    end
  end

  assign last_xfer = (state_q == StActive) && (list_cnt == 5'd1);

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    wb_d    = wb_q;
    unique case (state_q)
      StIdle: begin
        if (bus.LOAD) begin
          if (load_cnt == 5'd0) begin
            wb_d = bus.BASE;
          end else begin
            state_d = StActive;
            list_d  = bus.IR_LIST;
            unique case ({bus.P_BIT, bus.U_BIT})
              2'b01: begin
                addr_d = bus.BASE;
                wb_d   = bus.BASE + step_n;
              end
              2'b11: begin
                addr_d = bus.BASE + ADDR_W'(STEP);
                wb_d   = bus.BASE + step_n;
              end
              2'b00: begin
                addr_d = bus.BASE - step_n + ADDR_W'(STEP);
                wb_d   = bus.BASE - step_n;
              end
              default: begin
                addr_d = bus.BASE - step_n;
                wb_d   = bus.BASE - step_n;
              end
            endcase
          end
        end
      end
      StActive: begin
        if (bus.NEXT) begin
          // Clearing the lowest set bit advances to the next register in ascending order.
          list_d = list_q & (list_q - 16'd1);
          addr_d = addr_q + ADDR_W'(STEP);
          if (last_xfer) begin
            state_d = StDone;
            list_d  = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      list_q  <= '0;
      addr_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    bus.REG_NUM    = low_idx;
    bus.ADDR       = addr_q;
    bus.WB_ADDR    = wb_q;
    bus.COUNT      = (state_q == StActive) ? list_cnt : 5'd0;
    bus.LSM_DETECT = (state_q == StActive);
    bus.LSM_END    = last_xfer;
    bus.BUSY       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer: all four addressing modes, empty list, address wrap,
// stall with ignored LOAD, and asynchronous reset mid-sequence.
module tb_lsm_sequencer;

  logic CLK;
  logic nRESET;
  int   n_checks;
  int   n_errors;

  lsm_sequencer_if #(.ADDR_W(32)) bus ();

  lsm_sequencer #(
    .ADDR_W(32),
    .STEP  (4)
  ) dut (
    .CLK   (CLK),
    .nRESET(nRESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_reg"},  32'(bus.REG_NUM),    32'd0);
    check({tag, "_addr"}, bus.ADDR,            32'd0);
    check({tag, "_wb"},   bus.WB_ADDR,         32'd0);
    check({tag, "_cnt"},  32'(bus.COUNT),      32'd0);
    check({tag, "_det"},  32'(bus.LSM_DETECT), 32'd0);
    check({tag, "_end"},  32'(bus.LSM_END),    32'd0);
    check({tag, "_busy"}, 32'(bus.BUSY),       32'd0);
  endtask

  // Runs a full sequence; start/wb are hand-computed by the caller.
  task automatic run_seq(input string tag, input logic [15:0] list, input logic [31:0] base,
                         input logic p, input logic u, input logic [31:0] start,
                         input logic [31:0] wb, input bit stall);
    logic [31:0] exp_addr;
    int          rem;
    bit          stalled;
    rem = 0;
    for (int i = 0; i < 16; i++) rem += int'(list[i]);
    @(negedge CLK);
    bus.IR_LIST = list;
    bus.BASE    = base;
    bus.P_BIT   = p;
    bus.U_BIT   = u;
    bus.LOAD    = 1'b1;
    bus.NEXT    = 1'b0;
    @(negedge CLK);
    bus.LOAD    = 1'b0;
    // Inputs scrambled after capture must not matter.
    bus.IR_LIST = 16'h1234;
    bus.BASE    = 32'hDEAD0000;
    bus.P_BIT   = ~p;
    bus.U_BIT   = ~u;
    exp_addr    = start;
    stalled     = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (list[r]) begin
        check($sformatf("%s_reg%0d", tag, r),  32'(bus.REG_NUM),    32'(r));
        check($sformatf("%s_addr%0d", tag, r), bus.ADDR,            exp_addr);
        check($sformatf("%s_cnt%0d", tag, r),  32'(bus.COUNT),      32'(rem));
        check($sformatf("%s_end%0d", tag, r),  32'(bus.LSM_END),    32'(rem == 1));
        check($sformatf("%s_det%0d", tag, r),  32'(bus.LSM_DETECT), 32'd1);
        check($sformatf("%s_wb%0d", tag, r),   bus.WB_ADDR,         wb);
        if (stall && !stalled) begin
          stalled = 1'b1;
          for (int k = 0; k < 5; k++) begin
            bus.LOAD    = 1'b1;
            bus.IR_LIST = 16'h00F0;
            bus.BASE    = 32'h00005000;
            @(negedge CLK);
            check($sformatf("%s_hold_reg%0d", tag, k),  32'(bus.REG_NUM), 32'(r));
            check($sformatf("%s_hold_addr%0d", tag, k), bus.ADDR,         exp_addr);
            check($sformatf("%s_hold_cnt%0d", tag, k),  32'(bus.COUNT),   32'(rem));
          end
          bus.LOAD = 1'b0;
        end
        bus.NEXT = 1'b1;
        @(negedge CLK);
        exp_addr = exp_addr + 32'd4;
        rem--;
      end
    end
    bus.NEXT = 1'b0;
    check({tag, "_done_busy"}, 32'(bus.BUSY),       32'd1);
    check({tag, "_done_det"},  32'(bus.LSM_DETECT), 32'd0);
    check({tag, "_done_end"},  32'(bus.LSM_END),    32'd0);
    check({tag, "_done_cnt"},  32'(bus.COUNT),      32'd0);
    check({tag, "_done_wb"},   bus.WB_ADDR,         wb);
    @(negedge CLK);
    check({tag, "_idle_busy"}, 32'(bus.BUSY),       32'd0);
    check({tag, "_idle_wb"},   bus.WB_ADDR,         wb);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    nRESET      = 1'b0;
    bus.LOAD    = 1'b0;
    bus.NEXT    = 1'b0;
    bus.IR_LIST = '0;
    bus.P_BIT   = 1'b0;
    bus.U_BIT   = 1'b0;
    bus.BASE    = '0;
    #1;
    check_reset_values("por");
    @(negedge CLK);
    nRESET = 1'b1;

    run_seq("ia", 16'h8005, 32'h100, 1'b0, 1'b1, 32'h100, 32'h10C, 1'b0);
    run_seq("ib", 16'h8005, 32'h100, 1'b1, 1'b1, 32'h104, 32'h10C, 1'b0);
    run_seq("da", 16'h8005, 32'h100, 1'b0, 1'b0, 32'h0F8, 32'h0F4, 1'b0);
    run_seq("db", 16'h8005, 32'h100, 1'b1, 1'b0, 32'h0F4, 32'h0F4, 1'b0);
    run_seq("stall", 16'h8005, 32'h100, 1'b0, 1'b1, 32'h100, 32'h10C, 1'b1);
    run_seq("wrap", 16'hFFFF, 32'hFFFFFFF8, 1'b0, 1'b1, 32'hFFFFFFF8, 32'h38, 1'b0);

    // Empty list: write-back only, no sequence; NEXT alongside must be ignored.
    @(negedge CLK);
    bus.IR_LIST = 16'h0000;
    bus.BASE    = 32'h200;
    bus.LOAD    = 1'b1;
    bus.NEXT    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus.LOAD = 1'b0;
      check($sformatf("empty_det%0d", k),  32'(bus.LSM_DETECT), 32'd0);
      check($sformatf("empty_busy%0d", k), 32'(bus.BUSY),       32'd0);
      check($sformatf("empty_wb%0d", k),   bus.WB_ADDR,         32'h200);
    end
    bus.NEXT = 1'b0;

    // Asynchronous reset in the middle of a sequence.
    @(negedge CLK);
    bus.IR_LIST = 16'h000F;
    bus.BASE    = 32'h400;
    bus.P_BIT   = 1'b0;
    bus.U_BIT   = 1'b1;
    bus.LOAD    = 1'b1;
    @(negedge CLK);
    bus.LOAD = 1'b0;
    bus.NEXT = 1'b1;
    @(negedge CLK);
    bus.NEXT = 1'b0;
    check("mid_pre_addr", bus.ADDR,    32'h404);
    check("mid_pre_wb",   bus.WB_ADDR, 32'h410);
    nRESET = 1'b0;
    #1;
    check_reset_values("mid");
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    check("mid_after_busy", 32'(bus.BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
